pc_stack_unit: RTL and testbench

Parametrised program-counter unit. It holds the PC register, the PCMUX (increment, EAB, bus, stack-pop), the +1 incrementer, and a hardware return-address stack (RAS) that supports subroutine call and return without bus traffic. It sits in the fetch datapath and drives the PC onto the bus and the memory address path.

---
 rtl/pc_pkg.sv | 17 +
 rtl/return_stack.sv | 68 ++++++
 rtl/pc_stack_unit.sv | 100 ++++++++++
 tb/tb_pc_stack_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: PCMUX selects, default reset
// vector and the width helper for the return-stack depth count.
package pc_pkg;

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_EAB = 2'b01;
  localparam logic [1:0] SEL_BUS = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  localparam logic [15:0] PC_RESET_VEC = 16'h3000;

  // A depth counter must represent 0..depth inclusive.
  function automatic int depth_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack indexed by depth. Supports push, pop and swap
// (push+pop); a push into a full stack is dropped, a pop or swap on empty is a no-op.
module return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              top,
  output logic [depth_width(DEPTH)-1:0] depth,
  output logic                          full,
  output logic                          empty
);

  localparam int DW = depth_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  // wr_idx is only meaningful when not full, top_idx only when not empty.
  assign wr_idx  = AW'(depth_q);
  assign top_idx = AW'(depth_q - DW'(1));
  assign top     = empty ? '0 : entries_q[top_idx];
  assign depth   = depth_q;

  always_comb begin
    entries_d = entries_q;
    depth_d   = depth_q;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          entries_d[wr_idx] = wdata;
          depth_d           = depth_q + DW'(1);
        end
      end
      2'b01: begin
        if (!empty) depth_d = depth_q - DW'(1);
      end
      2'b11: begin
        if (!empty) entries_d[top_idx] = wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Entry contents are don't-care after reset; only the depth is cleared.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter unit: PC register, PCMUX, incrementer and a hardware
// return-address stack for call/return/swap, with sticky overflow/underflow flags.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    selPC,
  input  logic                          ldPC,
  input  logic                          push,
  input  logic [WIDTH-1:0]              eabOut,
  input  logic [WIDTH-1:0]              Buss,
  input  logic                          clrErr,
  output logic [WIDTH-1:0]              PC,
  output logic [depth_width(DEPTH)-1:0] rasDepth,
  output logic                          rasEmpty,
  output logic                          rasFull,
  output logic                          overflow,
  output logic                          underflow
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic             overflow_q;
  logic             overflow_d;
  logic             underflow_q;
  logic             underflow_d;

  logic             is_ret;
  logic             rs_push;
  logic             rs_pop;
  logic [WIDTH-1:0] rs_top;
  logic             rs_full;
  logic             rs_empty;

  assign pc_inc  = pc_q + WIDTH'(1);
  assign is_ret  = (selPC == SEL_RET);
  // The stack itself drops full pushes and ignores empty pops/swaps.
  assign rs_push = ldPC & push;
  assign rs_pop  = ldPC & is_ret;

  return_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk  (clk),
    .reset(reset),
    .push (rs_push),
    .pop  (rs_pop),
    .wdata(pc_inc),
    .top  (rs_top),
    .depth(rasDepth),
    .full (rs_full),
    .empty(rs_empty)
  );

  always_comb begin
    pc_d = pc_q;
    if (ldPC) begin
      case (selPC)
        SEL_INC: pc_d = pc_inc;
        SEL_EAB: pc_d = eabOut;
        SEL_BUS: pc_d = Buss;
        default: pc_d = rs_empty ? pc_q : rs_top;
      endcase
    end
  end

  // Clear first so a coinciding error event still leaves the flag set.
  always_comb begin
    overflow_d  = clrErr ? 1'b0 : overflow_q;
    underflow_d = clrErr ? 1'b0 : underflow_q;
    if (ldPC && push && !is_ret && rs_full) overflow_d = 1'b1;
    if (ldPC && is_ret && rs_empty)         underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_VEC;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign PC        = pc_q;
  assign rasEmpty  = rs_empty;
  assign rasFull   = rs_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [1:0]       sel_pc;
  logic             ld_pc;
  logic             push;
  logic [WIDTH-1:0] eab_out;
  logic [WIDTH-1:0] buss;
  logic             clr_err;
  logic [WIDTH-1:0] pc;
  logic [2:0]       ras_depth;
  logic             ras_empty;
  logic             ras_full;
  logic             overflow;
  logic             underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] ras_q[$];
  logic             m_ov;
  logic             m_un;

  pc_stack_unit #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VEC(16'h3000)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .selPC    (sel_pc),
    .ldPC     (ld_pc),
    .push     (push),
    .eabOut   (eab_out),
    .Buss     (buss),
    .clrErr   (clr_err),
    .PC       (pc),
    .rasDepth (ras_depth),
    .rasEmpty (ras_empty),
    .rasFull  (ras_full),
    .overflow (overflow),
    .underflow(underflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one clock edge with the currently driven inputs
  task automatic model_step();
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] ret_addr;
    logic             ov_n;
    logic             un_n;
    if (reset) begin
      m_pc = 16'h3000;
      ras_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      ov_n = clr_err ? 1'b0 : m_ov;
      un_n = clr_err ? 1'b0 : m_un;
      if (ld_pc) begin
        inc = m_pc + 16'd1;
        if (sel_pc == 2'b11) begin
          if (ras_q.size() == 0) begin
            un_n = 1'b1;
          end else begin
            ret_addr = ras_q[ras_q.size()-1];
            if (push) ras_q[ras_q.size()-1] = inc;
            else      void'(ras_q.pop_back());
            m_pc = ret_addr;
          end
        end else begin
          if (push) begin
            if (ras_q.size() < DEPTH) ras_q.push_back(inc);
            else                      ov_n = 1'b1;
          end
          case (sel_pc)
            2'b00:   m_pc = inc;
            2'b01:   m_pc = eab_out;
            default: m_pc = buss;
          endcase
        end
      end
      m_ov = ov_n;
      m_un = un_n;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},        pc,        m_pc);
    check_eq({tag, ".depth"},     ras_depth, ras_q.size());
    check_eq({tag, ".empty"},     ras_empty, ras_q.size() == 0);
    check_eq({tag, ".full"},      ras_full,  ras_q.size() == DEPTH);
    check_eq({tag, ".overflow"},  overflow,  m_ov);
    check_eq({tag, ".underflow"}, underflow, m_un);
  endtask

  // Driver: apply inputs, clock once, update model, compare #1 after the edge
  task automatic drive(input string tag, input logic rst, input logic ld, input logic ph,
                       input logic [1:0] sel, input logic [WIDTH-1:0] eab,
                       input logic [WIDTH-1:0] bus, input logic clr);
    reset   = rst;
    ld_pc   = ld;
    push    = ph;
    sel_pc  = sel;
    eab_out = eab;
    buss    = bus;
    clr_err = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    drive("reset", 1'b1, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic load_bus(input logic [WIDTH-1:0] v);
    drive("load", 1'b0, 1'b1, 1'b0, 2'b10, '0, v, 1'b0);
  endtask

  task automatic call_to(input logic [WIDTH-1:0] target);
    drive("call", 1'b0, 1'b1, 1'b1, 2'b01, target, '0, 1'b0);
  endtask

  task automatic ret_op();
    drive("ret", 1'b0, 1'b1, 1'b0, 2'b11, '0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; ld_pc = 1'b0; push = 1'b0; sel_pc = 2'b00;
    eab_out = '0; buss = '0; clr_err = 1'b0;
    m_pc = '0; m_ov = 1'b0; m_un = 1'b0;

    // Reset and increment
    do_reset();
    check_eq("rst_pc", pc, 16'h3000);
    for (int i = 0; i < 3; i++) drive("inc", 1'b0, 1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
    check_eq("inc3_pc", pc, 16'h3003);

    // Wrap and hold
    load_bus(16'hFFFF);
    drive("wrap", 1'b0, 1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
    check_eq("wrap_pc", pc, 16'h0000);
    drive("hold", 1'b0, 1'b0, 1'b1, 2'b01, 16'h1234, '0, 1'b0);
    check_eq("hold_pc", pc, 16'h0000);

    // Call / return
    load_bus(16'h3005);
    call_to(16'h4000);
    check_eq("call_depth", ras_depth, 3'd1);
    ret_op();
    check_eq("ret_pc", pc, 16'h3006);

    // Overflow then drain to underflow
    load_bus(16'h0010);
    for (int i = 2; i <= 6; i++) call_to(WIDTH'(i * 16));
    check_eq("ovf_flag", overflow, 1'b1);
    check_eq("ovf_pc", pc, 16'h0060);
    for (int i = 0; i < 4; i++) ret_op();
    check_eq("drain_pc", pc, 16'h0011);
    ret_op();
    check_eq("unf_flag", underflow, 1'b1);
    check_eq("unf_pc", pc, 16'h0011);
    drive("clr", 1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
    check_eq("clr_flags", {overflow, underflow}, 2'b00);

    // Swap
    load_bus(16'h01FF);
    call_to(16'h0500);
    drive("swap", 1'b0, 1'b1, 1'b1, 2'b11, '0, '0, 1'b0);
    check_eq("swap_pc", pc, 16'h0200);
    ret_op();
    check_eq("swap_top", pc, 16'h0501);

    // Swap on empty is an underflow; clear coinciding with new error keeps it set
    drive("swap_empty", 1'b0, 1'b1, 1'b1, 2'b11, '0, '0, 1'b1);
    check_eq("swap_empty_unf", underflow, 1'b1);

    // Reset mid-operation
    load_bus(16'h0100);
    for (int i = 0; i < 5; i++) call_to(WIDTH'(16'h0200 + i));
    ret_op();
    check_eq("mid_depth", ras_depth, 3'd3);
    drive("rst_mid", 1'b1, 1'b1, 1'b1, 2'b01, 16'h7777, '0, 1'b0);
    check_eq("rst_mid_pc", pc, 16'h3000);
    check_eq("rst_mid_depth", ras_depth, 3'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive("rand",
            ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)),
            16'($urandom),
            ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom),
            ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
